coin_payout: RTL and testbench

Change-payout controller on the customer side of the coin_avtomat `change` output. It accepts a change amount, pays it out greedily as discrete coin-eject pulses (50, 10, 5), tracks a per-denomination coin-tube inventory, and reports completion or shortfall. It sits between the vending FSM and the coin-hopper solenoid drivers.

---
 rtl/coin_payout.sv | 140 ++++++++++++++
 tb/tb_coin_payout.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_payout.sv
// Change-payout controller: pays an amount greedily as 50/10/5 coin-eject pulses
// from three finite coin tubes and reports completion or an unpaid remainder.
module coin_payout #(
    parameter int unsigned PULSE_LEN = 3,
    parameter int unsigned GAP_LEN   = 3,
    parameter int unsigned TUBE_INIT = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] change_i,
    input  logic       load_i,
    input  logic       refill_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       short_o,
    output logic [2:0] coin_o,
    output logic [7:0] remain_o,
    output logic [2:0] tube50_o,
    output logic [2:0] tube10_o,
    output logic [2:0] tube5_o
);

    localparam int unsigned MaxLen = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam logic [2:0]  TubeInit = 3'(TUBE_INIT);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StEject,
        StGap,
        StFinish
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [7:0]      remain_q;
    logic [2:0]      tube50_q, tube10_q, tube5_q;
    logic [2:0]      coin_q;
    logic            busy_q, done_q, short_q;

    logic [2:0]      pick_coin;
    logic [7:0]      pick_val;

    // Largest denomination that fits the remainder and still has a coin in its tube.
    always_comb begin
        pick_coin = 3'b000;
        pick_val  = 8'd0;
        if (remain_q >= 8'd50 && tube50_q != 3'd0) begin
            pick_coin = 3'b100;
            pick_val  = 8'd50;
        end else if (remain_q >= 8'd10 && tube10_q != 3'd0) begin
            pick_coin = 3'b010;
            pick_val  = 8'd10;
        end else if (remain_q >= 8'd5 && tube5_q != 3'd0) begin
            pick_coin = 3'b001;
            pick_val  = 8'd5;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            remain_q <= 8'd0;
            tube50_q <= TubeInit;
            tube10_q <= TubeInit;
            tube5_q  <= TubeInit;
            coin_q   <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_i) begin
                        remain_q <= change_i;
                        short_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StSelect;
                    end
                    if (refill_i) begin
                        tube50_q <= TubeInit;
                        tube10_q <= TubeInit;
                        tube5_q  <= TubeInit;
                    end
                end
                StSelect: begin
                    if (pick_coin != 3'b000) begin
                        remain_q <= remain_q - pick_val;
                        if (pick_coin[2]) tube50_q <= tube50_q - 3'd1;
                        if (pick_coin[1]) tube10_q <= tube10_q - 3'd1;
                        if (pick_coin[0]) tube5_q  <= tube5_q - 3'd1;
                        coin_q  <= pick_coin;
                        cnt_q   <= CntW'(PULSE_LEN - 1);
                        state_q <= StEject;
                    end else begin
                        if (remain_q != 8'd0) short_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end
                end
                StEject: begin
                    if (cnt_q == '0) begin
                        coin_q  <= 3'b000;
                        cnt_q   <= CntW'(GAP_LEN - 1);
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        state_q <= StSelect;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign short_o  = short_q;
    assign coin_o   = coin_q;
    assign remain_o = remain_q;
    assign tube50_o = tube50_q;
    assign tube10_o = tube10_q;
    assign tube5_o  = tube5_q;

endmodule

// File: tb/tb_coin_payout.sv
// Randomized scoreboard bench for coin_payout: a greedy payout model predicts every coin
// (value and start edge) and every completion, and a negedge monitor checks them.
module tb_coin_payout;

    localparam int PULSE_LEN = 3;
    localparam int GAP_LEN   = 3;
    localparam int TUBE_INIT = 7;
    localparam int P         = 1 + PULSE_LEN + GAP_LEN;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] change_i = 8'd0;
    logic       load_i = 1'b0;
    logic       refill_i = 1'b0;
    logic       busy_o, done_o, short_o;
    logic [2:0] coin_o;
    logic [7:0] remain_o;
    logic [2:0] tube50_o, tube10_o, tube5_o;

    coin_payout #(
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .TUBE_INIT (TUBE_INIT)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .change_i (change_i),
        .load_i   (load_i),
        .refill_i (refill_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .short_o  (short_o),
        .coin_o   (coin_o),
        .remain_o (remain_o),
        .tube50_o (tube50_o),
        .tube10_o (tube10_o),
        .tube5_o  (tube5_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] coin;
        int         edge_no;
    } coin_exp_t;

    typedef struct {
        int edge_no;
        int remain;
        int short_flag;
        int t50;
        int t10;
        int t5;
    } done_exp_t;

    coin_exp_t coin_q[$];
    done_exp_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int tm[3];          // model tubes: [0]=50, [1]=10, [2]=5
    bit started = 0;
    bit abort = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Greedy payout from the tube model; records the coins and the completion it implies.
    task automatic model_load(input int amt, input bit with_refill, input int accept);
        int d[3] = '{50, 10, 5};
        logic [2:0] oh[3] = '{3'b100, 3'b010, 3'b001};
        int rem = amt;
        int n = 0;
        bit found;
        if (with_refill) tm = '{TUBE_INIT, TUBE_INIT, TUBE_INIT};
        do begin
            found = 0;
            for (int i = 0; i < 3; i++) begin
                if (!found && d[i] <= rem && tm[i] > 0) begin
                    found = 1;
                    rem -= d[i];
                    tm[i]--;
                    coin_q.push_back('{oh[i], accept + n * P + 1});
                    n++;
                end
            end
        end while (found);
        done_q.push_back('{accept + n * P + 1, rem, (rem != 0) ? 1 : 0, tm[0], tm[1], tm[2]});
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    logic [2:0] prev_coin = 3'b000;
    int width = 0;
    always @(negedge clk) begin
        coin_exp_t ce;
        done_exp_t de;
        if (started) begin
            if (coin_o != 3'b000) begin
                check("coin_onehot", int'($onehot(coin_o)), 1);
                if (prev_coin == 3'b000) begin
                    width = 1;
                    if (coin_q.size() == 0) begin
                        check("unexpected_coin", int'(coin_o), 0);
                    end else begin
                        ce = coin_q.pop_front();
                        check("coin_value", int'(coin_o), int'(ce.coin));
                        check("coin_edge", cyc, ce.edge_no);
                    end
                end else begin
                    check("coin_steady", int'(coin_o), int'(prev_coin));
                    width++;
                end
            end else if (prev_coin != 3'b000 && !abort) begin
                check("pulse_len", width, PULSE_LEN);
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    de = done_q.pop_front();
                    check("done_edge", cyc, de.edge_no);
                    check("done_remain", int'(remain_o), de.remain);
                    check("done_short", int'(short_o), de.short_flag);
                    check("done_busy", int'(busy_o), 1);
                    check("done_tube50", int'(tube50_o), de.t50);
                    check("done_tube10", int'(tube10_o), de.t10);
                    check("done_tube5", int'(tube5_o), de.t5);
                end
            end
            prev_coin = coin_o;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_load(input int amt, input bit with_refill);
        model_load(amt, with_refill, cyc + 1);
        change_i = 8'(amt);
        load_i = 1'b1;
        refill_i = with_refill;
        @(negedge clk);
        load_i = 1'b0;
        refill_i = 1'b0;
        check("accept_busy", int'(busy_o), 1);
        check("accept_short", int'(short_o), 0);
    endtask

    // Waits for done_o, optionally poking load/refill while busy; then checks return to idle.
    task automatic wait_done(input bit poke);
        bit seen = 0;
        for (int t = 0; t < 400 && !seen; t++) begin
            if (poke && $urandom_range(0, 2) == 0) begin
                load_i = 1'b1;
                refill_i = 1'b1;
                change_i = 8'($urandom);
            end
            @(negedge clk);
            load_i = 1'b0;
            refill_i = 1'b0;
            if (done_o) seen = 1;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            coin_q.delete();
            done_q.delete();
        end else begin
            @(negedge clk);
            check("idle_busy", int'(busy_o), 0);
            check("idle_done", int'(done_o), 0);
            check("idle_coin", int'(coin_o), 0);
        end
    endtask

    task automatic do_load(input int amt, input bit with_refill, input bit poke);
        start_load(amt, with_refill);
        wait_done(poke);
    endtask

    task automatic idle_refill();
        refill_i = 1'b1;
        @(negedge clk);
        refill_i = 1'b0;
        tm = '{TUBE_INIT, TUBE_INIT, TUBE_INIT};
        check("refill_tube50", int'(tube50_o), TUBE_INIT);
        check("refill_tube10", int'(tube10_o), TUBE_INIT);
        check("refill_tube5", int'(tube5_o), TUBE_INIT);
        check("refill_busy", int'(busy_o), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_coin"}, int'(coin_o), 0);
        check({tag, "_remain"}, int'(remain_o), 0);
        check({tag, "_short"}, int'(short_o), 0);
        check({tag, "_tube50"}, int'(tube50_o), TUBE_INIT);
        check({tag, "_tube10"}, int'(tube10_o), TUBE_INIT);
        check({tag, "_tube5"}, int'(tube5_o), TUBE_INIT);
    endtask

    initial begin
        tm = '{TUBE_INIT, TUBE_INIT, TUBE_INIT};
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        started = 1;
        check_reset_state("reset");

        do_load(65, 0, 0);

        // Reset two edges into a 65 payout, mid-way through the first pulse.
        start_load(65, 0);
        @(negedge clk);
        abort = 1;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_reset_state("abort");
        coin_q.delete();
        done_q.delete();
        tm = '{TUBE_INIT, TUBE_INIT, TUBE_INIT};
        repeat (3) @(negedge clk);
        abort = 0;
        repeat (20) @(negedge clk);

        do_load(100, 1, 0);

        idle_refill();
        for (int i = 0; i < 7; i++) do_load(50, 0, 0);
        do_load(50, 0, 0);

        idle_refill();
        do_load(67, 0, 0);
        do_load(5, 0, 0);
        do_load(0, 0, 1);
        do_load(255, 0, 1);

        for (int i = 0; i < 40; i++) begin
            int amt;
            case ($urandom_range(0, 3))
                0: amt = 5 * $urandom_range(0, 51);
                1: amt = $urandom_range(0, 20);
                default: amt = $urandom_range(0, 255);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_load(amt, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        repeat (5) @(negedge clk);
        check("leftover_coins", coin_q.size(), 0);
        check("leftover_done", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
